// File: rtl/lc3b_types.sv
// Shared LC-3b types: datapath word, multiply/divide opcode and the
// divide-by-zero result constant.
package lc3b_types;

  typedef logic [15:0] lc3b_word;

  typedef enum logic {
    MD_MUL = 1'b0,
    MD_DIV = 1'b1
  } lc3b_mdop;

  localparam lc3b_word MD_DIV_ZERO_RESULT = 16'hFFFF;

endpackage

// File: rtl/mult_div_ctrl_lat_counter.sv
// Loadable down-counter that times the multiply/divide unit latency.
module md_lat_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             clear,
  input  logic             dec,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] cnt,
  output logic             is_one
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - WIDTH'(1);
    end
  end

  assign is_one = (cnt == WIDTH'(1));

endmodule

// File: rtl/mult_div_ctrl.sv
// Sequences one MUL/DIV through the multi-cycle unit: latches operands, gates the
// unit clock-enable for its latency, captures the result and pulses done.
module mult_div_ctrl
  import lc3b_types::*;
#(
  parameter int unsigned MULT_LAT = 2,
  parameter int unsigned DIV_LAT  = 8
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     req,
  input  lc3b_mdop op,
  input  lc3b_word a,
  input  lc3b_word b,
  input  logic     flush,
  input  lc3b_word unit_result,
  output logic     multi_en,
  output logic     div_en,
  output lc3b_word unit_a,
  output lc3b_word unit_b,
  output logic     stall,
  output logic     done,
  output lc3b_word result
);

  localparam int unsigned MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int unsigned CNT_W   = $clog2(MAX_LAT) + 1;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StCapture,
    StDone
  } state_e;

  state_e     state_q, state_d;
  lc3b_mdop   op_q;
  logic [CNT_W-1:0] cnt, cnt_load_val;
  logic       cnt_is_one;
  logic       cnt_load, cnt_clear, cnt_dec;
  logic       latch_ops, load_zero, capture;

  assign cnt_load_val = (op == MD_DIV) ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);

  md_lat_counter #(
    .WIDTH(CNT_W)
  ) u_lat_counter (
    .clk     (clk),
    .reset   (reset),
    .load    (cnt_load),
    .clear   (cnt_clear),
    .dec     (cnt_dec),
    .load_val(cnt_load_val),
    .cnt     (cnt),
    .is_one  (cnt_is_one)
  );

  always_comb begin
    state_d   = state_q;
    cnt_load  = 1'b0;
    cnt_clear = 1'b0;
    cnt_dec   = 1'b0;
    latch_ops = 1'b0;
    load_zero = 1'b0;
    capture   = 1'b0;
    multi_en  = 1'b0;
    div_en    = 1'b0;
    done      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req && !flush) begin
          latch_ops = 1'b1;
          if (op == MD_DIV && b == '0) begin
            load_zero = 1'b1;
            state_d   = StDone;
          end else begin
            cnt_load = 1'b1;
            state_d  = StBusy;
          end
        end
      end
      StBusy: begin
        multi_en = (op_q == MD_MUL);
        div_en   = (op_q == MD_DIV);
        cnt_dec  = 1'b1;
        if (cnt_is_one) state_d = StCapture;
      end
      StCapture: begin
        capture = 1'b1;
        state_d = StDone;
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Flush aborts in any state; the aborted op never writes result.
    if (flush) begin
      state_d   = StIdle;
      cnt_clear = 1'b1;
      cnt_load  = 1'b0;
      capture   = 1'b0;
      load_zero = 1'b0;
    end
  end

  assign stall = req && (state_q != StDone);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      op_q    <= MD_MUL;
      unit_a  <= '0;
      unit_b  <= '0;
      result  <= '0;
    end else begin
      state_q <= state_d;
      if (latch_ops) begin
        op_q   <= op;
        unit_a <= a;
        unit_b <= b;
      end
      if (load_zero) begin
        result <= MD_DIV_ZERO_RESULT;
      end else if (capture) begin
        result <= unit_result;
      end
    end
  end

endmodule
